regfile_exec_seq: RTL



---
 rtl/regfile_exec_seq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/regfile_exec_seq.sv
// Command sequencer for the 15x8 register file: accepts ADD/SUB/MAC/MOVE,
// issues a synchronous read, computes the result and writes it back.
module regfile_exec_seq #(
  parameter int M = 4,
  parameter int N = 15,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [M-1:0] cmd_dst,
  input  logic [M-1:0] cmd_src1,
  input  logic [M-1:0] cmd_src2,
  input  logic [M-1:0] cmd_src3,
  output logic         rf_read_en,
  output logic [M-1:0] rf_read_reg1,
  output logic [M-1:0] rf_read_reg2,
  output logic [M-1:0] rf_read_reg3,
  input  logic [W-1:0] rf_read_data1,
  input  logic [W-1:0] rf_read_data2,
  input  logic [W-1:0] rf_read_data3,
  output logic         rf_write_en,
  output logic [M-1:0] rf_write_reg,
  output logic [W-1:0] rf_write_data,
  output logic         res_valid,
  output logic [W-1:0] res_data,
  output logic         cmd_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, WRITE} state_t;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MAC  = 2'b10;
  // One extra bit so the limit stays representable even when N == 2**M.
  localparam logic [M:0] LP_NLIM = (M+1)'(N);

  state_t       r_state;
  state_t       w_next;
  logic [1:0]   r_op;
  logic [M-1:0] r_dst;
  logic         w_accept;
  logic         w_bad;
  logic [W-1:0] w_result;

  assign cmd_ready = (r_state == IDLE) && rst_n;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_bad     = ({1'b0, cmd_dst}  >= LP_NLIM) || ({1'b0, cmd_src1} >= LP_NLIM) ||
                     ({1'b0, cmd_src2} >= LP_NLIM) || ({1'b0, cmd_src3} >= LP_NLIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && !w_bad) w_next = ISSUE;
      ISSUE:   w_next = CAPTURE;
      CAPTURE: w_next = WRITE;
      WRITE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The low W bits of the full product depend only on the low W bits, so W-bit math suffices.
  always_comb begin
    w_result = rf_read_data1;
    case (r_op)
      OP_ADD:  w_result = rf_read_data1 + rf_read_data2;
      OP_SUB:  w_result = rf_read_data1 - rf_read_data2;
      OP_MAC:  w_result = rf_read_data1 * rf_read_data2 + rf_read_data3;
      default: w_result = rf_read_data1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_read_en    <= 1'b0;
      rf_read_reg1  <= '0;
      rf_read_reg2  <= '0;
      rf_read_reg3  <= '0;
      rf_write_en   <= 1'b0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
      res_valid     <= 1'b0;
      res_data      <= '0;
      cmd_err       <= 1'b0;
      r_op          <= '0;
      r_dst         <= '0;
    end else begin
      rf_read_en  <= 1'b0;
      rf_write_en <= 1'b0;
      res_valid   <= 1'b0;
      cmd_err     <= 1'b0;
      if (w_accept) begin
        if (w_bad) begin
          cmd_err <= 1'b1;
        end else begin
          rf_read_en   <= 1'b1;
          rf_read_reg1 <= cmd_src1;
          rf_read_reg2 <= cmd_src2;
          rf_read_reg3 <= cmd_src3;
          r_op         <= cmd_op;
          r_dst        <= cmd_dst;
        end
      end
      // Read data is valid during CAPTURE; register the result straight into the write port.
      if (r_state == CAPTURE) begin
        rf_write_en   <= 1'b1;
        rf_write_reg  <= r_dst;
        rf_write_data <= w_result;
        res_valid     <= 1'b1;
        res_data      <= w_result;
      end
    end
  end

endmodule
